// File: rtl/clas_pkg.sv
// ============================================================================
// Module      : clas_pkg
// Description : Shared constants for the CLAS result stage: datapath width,
//               op encodings and FIFO entry layout. Honours CLAS_RESULT_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clas_pkg;

    localparam int CLAS_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Entry layout: {flags, result}; flag offsets are relative to bit WIDTH.
    localparam int FLG_COUT = 0;
    localparam int FLG_ZERO = 1;
    localparam int FLG_NEG  = 2;
`ifdef CLAS_RESULT_OVF_EN
    localparam int FLG_OVF       = 3;
    localparam int ENT_FLAG_BITS = 4;
`else
    localparam int ENT_FLAG_BITS = 3;
`endif

    function automatic int entry_width(input int w);
        return w + ENT_FLAG_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clas_flag_gen.sv
// ============================================================================
// Module      : clas_flag_gen
// Description : Combinational flag derivation and self-check of a CLAS result
//               against a +/- b. Overflow flag only when CLAS_RESULT_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clas_flag_gen
    import clas_pkg::*;
#(
    parameter int WIDTH = CLAS_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [WIDTH-1:0] result,
    input  logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             mismatch
);

    logic [WIDTH:0] w_exp;

    // Subtract as a + ~b + 1 so the carry-out is the "no borrow" indication.
    always_comb begin
        if (sel == OP_ADD) begin
            w_exp = {1'b0, a} + {1'b0, b};
        end else begin
            w_exp = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        end
    end

    assign zero     = (result == '0);
    assign neg      = result[WIDTH-1];
    assign mismatch = (w_exp[WIDTH-1:0] != result) || (w_exp[WIDTH] != c_out);

`ifdef CLAS_RESULT_OVF_EN
    always_comb begin
        if (sel == OP_SUB) begin
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        end else begin
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/clas_result_stage.sv
// ============================================================================
// Module      : clas_result_stage
// Description : Capture stage for the CLAS adder: flags, sticky self-check and
//               a first-word fall-through FIFO. Option macro: CLAS_RESULT_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clas_result_stage
    import clas_pkg::*;
#(
    parameter int WIDTH = CLAS_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_sel,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_c_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_c_out,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     chk_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              EW       = entry_width(WIDTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          chk_err_q, chk_err_d;

    logic          w_zero, w_neg, w_mismatch;
    logic          w_push, w_pop;
    logic [EW-1:0] w_entry, w_head;
`ifdef CLAS_RESULT_OVF_EN
    logic          w_ovf;
`else
    logic          w_ovf_unused;
`endif

    clas_flag_gen #(
        .WIDTH    (WIDTH)
    ) u_flag_gen (
        .a        (in_a),
        .b        (in_b),
        .sel      (in_sel),
        .result   (in_result),
        .c_out    (in_c_out),
        .zero     (w_zero),
        .neg      (w_neg),
`ifdef CLAS_RESULT_OVF_EN
        .ovf      (w_ovf),
`else
        .ovf      (w_ovf_unused),
`endif
        .mismatch (w_mismatch)
    );

    // Ready/valid come straight from registered occupancy, so a pop never
    // re-opens a full FIFO in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_entry                   = '0;
        w_entry[WIDTH-1:0]        = in_result;
        w_entry[WIDTH + FLG_COUT] = in_c_out;
        w_entry[WIDTH + FLG_ZERO] = w_zero;
        w_entry[WIDTH + FLG_NEG]  = w_neg;
`ifdef CLAS_RESULT_OVF_EN
        w_entry[WIDTH + FLG_OVF]  = w_ovf;
`endif
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        chk_err_d = chk_err_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = w_entry;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            chk_err_d       = chk_err_q | w_mismatch;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            chk_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign w_head     = mem_q[rd_ptr_q];
    assign out_result = w_head[WIDTH-1:0];
    assign out_c_out  = w_head[WIDTH + FLG_COUT];
    assign out_zero   = w_head[WIDTH + FLG_ZERO];
    assign out_neg    = w_head[WIDTH + FLG_NEG];
`ifdef CLAS_RESULT_OVF_EN
    assign out_ovf    = w_head[WIDTH + FLG_OVF];
`else
    assign out_ovf    = 1'b0;
`endif
    assign count      = count_q;
    assign chk_err    = chk_err_q;

endmodule

`default_nettype wire
